// File: rtl/alarm_sequencer_pkg.sv
// rtl/alarm_sequencer_pkg.sv - shared state encoding and constants for the alarm sequencer
package alarm_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_DISARMED = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RINGING  = 2'd2,
    ST_SNOOZE   = 2'd3
  } alarm_state_t;

  localparam int SEC_PER_MIN = 60;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/alarm_sequencer_sec_countdown.sv
// rtl/alarm_sequencer_sec_countdown.sv - loadable seconds down-counter with registered zero flag
module sec_countdown #(
  parameter int TW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load,
  input  logic [TW-1:0] value,
  input  logic          sec_tick,
  output logic [TW-1:0] count,
  output logic          zero
);

  // Load wins over a coincident tick so a freshly loaded period is never shortened.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      zero  <= 1'b1;
    end else if (load) begin
      count <= value;
      zero  <= (value == '0);
    end else if (sec_tick && (count != '0)) begin
      count <= count - 1'b1;
      zero  <= (count == TW'(1));
    end
  end

endmodule

// File: rtl/alarm_sequencer.sv
// rtl/alarm_sequencer.sv - alarm time match and ring/snooze/dismiss sequencing
module alarm_sequencer
  import alarm_sequencer_pkg::*;
#(
  parameter int SNOOZE_MIN     = 5,
  parameter int MAX_SNOOZE     = 3,
  parameter int RING_TIMEOUT_S = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sec_tick,
  input  logic [4:0] cur_hour,
  input  logic [5:0] cur_min,
  input  logic [5:0] cur_sec,
  input  logic       set_en,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  input  logic       arm_toggle,
  input  logic       btn_snooze,
  input  logic       btn_clear,
  output logic       alarm,
  output logic       buzz_clear,
  output logic       armed,
  output logic       ringing,
  output logic       snoozing,
  output logic [2:0] snooze_left,
  output logic [4:0] alarm_hour,
  output logic [5:0] alarm_min
);

  localparam int TIMER_MAX = max_int(SNOOZE_MIN * SEC_PER_MIN, RING_TIMEOUT_S);
  localparam int TW        = $clog2(TIMER_MAX + 1);
  localparam logic [TW-1:0] RING_LOAD   = TW'(RING_TIMEOUT_S);
  localparam logic [TW-1:0] SNOOZE_LOAD = TW'(SNOOZE_MIN * SEC_PER_MIN);

  alarm_state_t  state, state_d;
  logic          alarm_d, clear_d;
  logic [2:0]    snooze_d;
  logic          tmr_load;
  logic [TW-1:0] tmr_value;
  logic [TW-1:0] tmr_count;
  logic          tmr_zero;
  logic          match, expire;

  sec_countdown #(.TW(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .value    (tmr_value),
    .sec_tick (sec_tick),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  assign match  = sec_tick && (cur_hour == alarm_hour) && (cur_min == alarm_min) && (cur_sec == 6'd0);
  // Expiry is the tick that takes the counter to zero (or finds it already there).
  assign expire = sec_tick && (tmr_zero || (tmr_count == TW'(1)));

  always_comb begin
    state_d   = state;
    alarm_d   = 1'b0;
    clear_d   = 1'b0;
    snooze_d  = snooze_left;
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state)
      ST_DISARMED: begin
        if (arm_toggle) state_d = ST_ARMED;
      end
      ST_ARMED: begin
        if (arm_toggle) begin
          state_d = ST_DISARMED;
        end else if (match) begin
          state_d   = ST_RINGING;
          alarm_d   = 1'b1;
          tmr_load  = 1'b1;
          tmr_value = RING_LOAD;
          snooze_d  = 3'(MAX_SNOOZE);
        end
      end
      ST_RINGING: begin
        if (arm_toggle) begin
          state_d = ST_DISARMED;
          clear_d = 1'b1;
        end else if (btn_clear) begin
          state_d = ST_ARMED;
          clear_d = 1'b1;
        end else if ((btn_snooze || expire) && (snooze_left != 3'd0)) begin
          state_d   = ST_SNOOZE;
          clear_d   = 1'b1;
          snooze_d  = snooze_left - 3'd1;
          tmr_load  = 1'b1;
          tmr_value = SNOOZE_LOAD;
        end else if (expire) begin
          state_d = ST_ARMED;
          clear_d = 1'b1;
        end
      end
      ST_SNOOZE: begin
        if (arm_toggle) begin
          state_d = ST_DISARMED;
          clear_d = 1'b1;
        end else if (btn_clear) begin
          state_d = ST_ARMED;
          clear_d = 1'b1;
        end else if (expire) begin
          state_d   = ST_RINGING;
          alarm_d   = 1'b1;
          tmr_load  = 1'b1;
          tmr_value = RING_LOAD;
        end
      end
      default: state_d = ST_DISARMED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_DISARMED;
      alarm       <= 1'b0;
      buzz_clear  <= 1'b0;
      armed       <= 1'b0;
      ringing     <= 1'b0;
      snoozing    <= 1'b0;
      snooze_left <= 3'd0;
      alarm_hour  <= 5'd0;
      alarm_min   <= 6'd0;
    end else begin
      state       <= state_d;
      alarm       <= alarm_d;
      buzz_clear  <= clear_d;
      armed       <= (state_d != ST_DISARMED);
      ringing     <= (state_d == ST_RINGING);
      snoozing    <= (state_d == ST_SNOOZE);
      snooze_left <= snooze_d;
      if (set_en && (set_hour < 5'd24) && (set_min < 6'd60)) begin
        alarm_hour <= set_hour;
        alarm_min  <= set_min;
      end
    end
  end

endmodule

// File: doc/alarm_sequencer.md
# alarm_sequencer

Generates the `alarm` request and the silencing pulse consumed by the buzzer. It holds the user-set alarm time and compares it against the running clock time once per second. It runs the ring/snooze/dismiss sequence and emits a one-cycle `buzz_clear` that the top level ORs into the buzzer's `btn_clear`, so the buzzer stops on snooze or timeout. Sits between the timekeeping core and the buzzer, driven by debounced button pulses.

## Interface
- `SNOOZE_MIN`, 5: snooze length in minutes (1..30)
- `MAX_SNOOZE`, 3: snoozes allowed per alarm event (1..7)
- `RING_TIMEOUT_S`, 60: seconds of unattended ringing before auto-snooze or auto-stop

Ports:
- `clk` in 1: system clock, `CLOCK_FREQ` from `defines.v`
- `reset` in 1: synchronous, active-high
- `sec_tick` in 1: one-cycle pulse per second from the timekeeping core
- `cur_hour` in 5, `cur_min` in 6, `cur_sec` in 6: current time, valid on the `sec_tick` cycle
- `set_en` in 1: load alarm time
- `set_hour` in 5, `set_min` in 6: new alarm time
- `arm_toggle`, `btn_snooze`, `btn_clear` in 1 each: debounced one-cycle pulses
- `alarm` out 1: one-cycle pulse, start ringing
- `buzz_clear` out 1: one-cycle pulse, silence buzzer
- `armed`, `ringing`, `snoozing` out 1 each: status levels
- `snooze_left` out 3: remaining snoozes
- `alarm_hour` out 5, `alarm_min` out 6: stored alarm time, for display

## Operation
- States: DISARMED, ARMED, RINGING, SNOOZE.
- `armed` = state != DISARMED; `ringing` = RINGING; `snoozing` = SNOOZE.
- Match condition: `sec_tick` && `cur_hour`==`alarm_hour` && `cur_min`==`alarm_min` && `cur_sec`==0.
- ARMED, on match: go to RINGING, pulse `alarm`, load the timer with `RING_TIMEOUT_S`, set `snooze_left`=`MAX_SNOOZE`.
- RINGING:
  - `btn_clear`: go to ARMED, pulse `buzz_clear`.
  - `btn_snooze` with `snooze_left`>0: go to SNOOZE, decrement `snooze_left`, load `SNOOZE_MIN`*60, pulse `buzz_clear`.
  - `btn_snooze` with `snooze_left`==0: ignored.
  - Timeout (timer reaches 0 on a `sec_tick`): behaves as `btn_snooze` if `snooze_left`>0, otherwise as `btn_clear`.
- SNOOZE:
  - Timer decrements on each `sec_tick`. At 0, go to RINGING, pulse `alarm`, reload `RING_TIMEOUT_S`.
  - `btn_clear`: go to ARMED, pulse `buzz_clear`.
  - `btn_snooze`: ignored.
- `arm_toggle`:
  - DISARMED → ARMED.
  - ARMED → DISARMED.
  - RINGING or SNOOZE → DISARMED with a `buzz_clear` pulse.
- The alarm stays ARMED after dismissal and fires again next day.
- `set_en`: loads `set_hour`/`set_min` only when `set_hour`<24 and `set_min`<60; out-of-range values are ignored. Accepted in any state; never changes state.
- Timer width: `$clog2(max(SNOOZE_MIN*60, RING_TIMEOUT_S)+1)`. Decrements saturate at 0.

## Timing
- Reset values: state DISARMED, `alarm_hour`=0, `alarm_min`=0, timer 0, `snooze_left`=0, and all pulse and status outputs 0.
- All outputs are registered.
- `alarm` and `buzz_clear` assert the cycle after the triggering input and last exactly one cycle. They are never high together.
- Priority within one cycle: `arm_toggle` > `btn_clear` > `btn_snooze` > timeout/match.
- A match in the same cycle as `set_en` compares against the old stored time. The new time applies from the next cycle.
- A match on a `sec_tick` in RINGING or SNOOZE is ignored; there is no re-trigger.
- `reset` asserted mid-ring forces DISARMED and produces no `buzz_clear`. The buzzer's own reset covers silencing.

## Structure
- State encoding (2-bit localparams) and the seconds-per-minute constant go in `defines.v`, next to `CLOCK_FREQ`.
- Sub-module `sec_countdown`: loadable down-counter with a synchronous `load`/`value` input, `sec_tick` enable, and a registered `zero` flag.
- The match comparator and the FSM stay in `alarm_sequencer`.

## Test plan
- Set alarm 07:30 and arm, then drive ticks through 07:29:59 → 07:30:00: one `alarm` pulse on the cycle after the 07:30:00 tick, `ringing`=1, `snooze_left`=3.
- While ringing, pulse `btn_snooze`: `buzz_clear` one cycle, `snoozing`=1, `snooze_left`=2. After 300 `sec_tick`s, `alarm` pulses again.
- Let ringing run with no button, `MAX_SNOOZE` exhausted: after 60 ticks, `buzz_clear` pulses and state is ARMED. A further `btn_snooze` while ringing with `snooze_left`=0 has no effect.
- In the same cycle, `btn_clear` + `btn_snooze` during RINGING → ARMED. `arm_toggle` + `btn_clear` → DISARMED with one `buzz_clear` pulse.
- `set_en` with 24:10 or 12:60 leaves the stored alarm time unchanged. `set_en` with 12:00 on the matching 12:00:00 tick does not fire when the old time differs.
- `reset` during SNOOZE: next cycle all outputs 0, no `alarm` pulse after the snooze period elapses.
